// File: rtl/bios_loader_pkg.sv
// Shared types and constants for the BIOS download path.
`timescale 1ns/1ps
package bios_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BIOS_AW        = 13;
  localparam int CNT_W          = 14;
  localparam int DATA_W         = 16;
  localparam int DEF_BIOS_WORDS = 8192;

  // Bit positions inside the sticky err vector.
  localparam int ERR_SEQ   = 0;
  localparam int ERR_SHORT = 1;

  // States in which the word FIFO is live and may be pushed or popped.
  function automatic logic is_busy(state_t s);
    return (s == ST_LOAD) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/bios_loader_if.sv
// Bus bundle between the HPS download port, the loader and the system BIOS RAM.
`timescale 1ns/1ps
interface bios_loader_if;
  import bios_loader_pkg::*;

  // Handshakes:
  //   HPS side: ioctl_wr is a one-cycle strobe; ioctl_addr/ioctl_dout are only
  //   meaningful while it is high. ioctl_wait is a registered "stop sending"
  //   hint that the source must honour before the next strobe.
  //   System side: bios_req is ready. A word moves when bios_req is high and a
  //   word is buffered; it then appears one cycle later as a single-cycle
  //   bios_wr with bios_addr/bios_din, which otherwise hold their last value.
  logic                ioctl_download;
  logic [15:0]         ioctl_index;
  logic                ioctl_wr;
  logic [24:0]         ioctl_addr;
  logic [DATA_W-1:0]   ioctl_dout;
  logic                ioctl_wait;
  logic                bios_req;
  logic [BIOS_AW-1:0]  bios_addr;
  logic [DATA_W-1:0]   bios_din;
  logic                bios_wr;
  logic                bios_loaded;
  logic [1:0]          err;

  // Environment side: HPS plus the consuming system.
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
    input  ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, err
  );

  // Loader side.
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, bios_req,
    output ioctl_wait, bios_addr, bios_din, bios_wr, bios_loaded, err
  );

endinterface

// File: rtl/bios_fifo.sv
// Synchronous word FIFO with fill level; clear empties it in one cycle.
`timescale 1ns/1ps
module bios_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 16
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  // Head word is visible combinationally so the caller can register it on pop.
  assign dout    = mem[rd_ptr];

  // Storage: data only, no reset needed since level gates every read.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally mod DEPTH; level tracks push minus pop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/bios_loader.sv
// Buffers a BIOS image streamed from the HPS and replays it into the system
// BIOS RAM, tracking completeness and sequencing errors.
`timescale 1ns/1ps
module bios_loader
  import bios_loader_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int BIOS_INDEX = 0,
  parameter int BIOS_WORDS = DEF_BIOS_WORDS
) (
  input  logic         clk_sys,
  input  logic         reset_n,
  bios_loader_if.slave bus,
  output state_t       dbg_state
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] WORDS_C  = CNT_W'(BIOS_WORDS);
  localparam logic [LW-1:0]    WAIT_LVL = LW'(DEPTH - 2);

  state_t              state;
  state_t              state_n;
  logic                dl_q;
  logic                bios_rise;
  logic                dl_fall;
  logic                clear;
  logic                wr_evt;
  logic                in_room;
  logic                push;
  logic                pop;
  logic                seq_err;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic [1:0]          err_q;
  logic                loaded_q;
  logic                wait_q;
  logic                wr_q;
  logic [BIOS_AW-1:0]  addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [DATA_W-1:0]   fifo_dout;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LW-1:0]       level;
  logic [LW-1:0]       level_n;
  logic                unused_addr_bits;

  // Only the word-address bits matter; the byte bit and high bits are ignored.
  assign unused_addr_bits = ^{bus.ioctl_addr[24:14], bus.ioctl_addr[0]};

  assign bus.ioctl_wait  = wait_q;
  assign bus.bios_addr   = addr_q;
  assign bus.bios_din    = din_q;
  assign bus.bios_wr     = wr_q;
  assign bus.bios_loaded = loaded_q;
  assign bus.err         = err_q;
  assign dbg_state       = state;

  // Download edge detection and the push/pop decisions for this cycle.
  always_comb begin
    bios_rise = bus.ioctl_download && !dl_q && (bus.ioctl_index == 16'(BIOS_INDEX));
    dl_fall   = !bus.ioctl_download && dl_q;
    in_room   = (in_cnt < WORDS_C);
    wr_evt    = (state == ST_LOAD) && bus.ioctl_wr && !bios_rise;
    push      = wr_evt && in_room && !fifo_full;
    // Overflow, FIFO-full drop and address out of sequence all flag err[0];
    // an out-of-sequence word is still stored at the counter address.
    seq_err   = wr_evt && (!in_room || fifo_full ||
                           (bus.ioctl_addr[13:1] != in_cnt[BIOS_AW-1:0]));
    pop       = is_busy(state) && !bios_rise && bus.bios_req && !fifo_empty;
  end

  // Next-state logic; a BIOS download rising edge restarts from any state.
  always_comb begin
    state_n = state;
    clear   = 1'b0;
    if (bios_rise) begin
      state_n = ST_LOAD;
      clear   = 1'b1;
    end else begin
      case (state)
        ST_LOAD:  if (dl_fall) state_n = ST_DRAIN;
        // Empty here means the final pop happened last cycle, so its bios_wr
        // is on the bus now and DONE is entered right after it.
        ST_DRAIN: if (fifo_empty) state_n = (out_cnt == WORDS_C) ? ST_DONE : ST_IDLE;
        default:  state_n = state;
      endcase
    end
  end

  // Fill level after this cycle, used to register ioctl_wait without lag.
  always_comb begin
    level_n = level;
    if (clear) level_n = '0;
    else       level_n = level + LW'(push) - LW'(pop);
  end

  // State register and download-level history.
  // dl_q resets high so a download still asserted across reset release is
  // not mistaken for a new rising edge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      dl_q  <= 1'b1;
    end else begin
      state <= state_n;
      dl_q  <= bus.ioctl_download;
    end
  end

  // Word counters, sticky error bits and the loaded flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      err_q    <= '0;
      loaded_q <= 1'b0;
    end else if (clear) begin
      in_cnt   <= '0;
      out_cnt  <= '0;
      err_q    <= '0;
      loaded_q <= 1'b0;
    end else begin
      if (push) in_cnt <= in_cnt + 1'b1;
      if (pop && (out_cnt != WORDS_C)) out_cnt <= out_cnt + 1'b1;
      if (seq_err) err_q[ERR_SEQ] <= 1'b1;
      if ((state == ST_DRAIN) && (state_n == ST_IDLE)) err_q[ERR_SHORT] <= 1'b1;
      if ((state == ST_DRAIN) && (state_n == ST_DONE)) loaded_q <= 1'b1;
    end
  end

  // BIOS RAM write port and HPS back-pressure, one cycle behind the pop.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      din_q  <= '0;
      wait_q <= 1'b0;
    end else begin
      wr_q   <= pop;
      wait_q <= is_busy(state_n) && (level_n >= WAIT_LVL);
      if (pop) begin
        addr_q <= out_cnt[BIOS_AW-1:0];
        din_q  <= fifo_dout;
      end
    end
  end

  bios_fifo #(
    .DEPTH (DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (push),
    .din     (bus.ioctl_dout),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

endmodule

// File: tb/tb_bios_loader.sv
// Directed bench for bios_loader: full images, back-pressure, short image,
// sequence error, reset mid-download and foreign-index downloads.
`timescale 1ns/1ps
module tb_bios_loader;
  import bios_loader_pkg::*;

  localparam int DEPTH = 16;
  localparam int WORDS = 8192;

  logic   clk_sys = 1'b0;
  logic   reset_n = 1'b1;
  state_t dbg_state;

  bios_loader_if bus();

  bios_loader #(
    .DEPTH      (DEPTH),
    .BIOS_INDEX (0),
    .BIOS_WORDS (WORDS)
  ) u_dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk_sys = ~clk_sys;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state: expected {addr,data} queue and captured writes.
  logic [28:0] exp_q[$];
  logic [12:0] got_addr [WORDS];
  logic [15:0] got_data [WORDS];
  int          cap_n = 0;
  int          total = 0;
  int          bad = 0;
  int          stall_timeouts = 0;
  logic        wait_seen = 1'b0;
  logic        wait_prev = 1'b0;
  int          lvl_at_rise = -1;

  // Monitor: outputs are registered, so sampling at negedge is stable.
  always @(negedge clk_sys) begin
    if (bus.bios_wr === 1'b1) begin
      if (cap_n < WORDS) begin
        got_addr[cap_n] = bus.bios_addr;
        got_data[cap_n] = bus.bios_din;
      end
      cap_n++;
    end
    if (bus.ioctl_wait === 1'b1 && !wait_prev && !wait_seen) begin
      wait_seen   = 1'b1;
      lvl_at_rise = int'(u_dut.u_fifo.level);
    end
    wait_prev = bus.ioctl_wait;
  end

  function automatic logic [15:0] word_data(input int i, input int seed);
    logic [31:0] v;
    v = 32'(i * 257 + seed * 965 + (i >> 5) * 3);
    return v[15:0];
  endfunction

  function automatic int count_bad();
    int b = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i >= cap_n || i >= WORDS) b++;
      else if (got_addr[i] !== exp_q[i][28:16] || got_data[i] !== exp_q[i][15:0]) b++;
    end
    return b;
  endfunction

  // Driver tasks
  task automatic clear_capture();
    cap_n = 0;
    exp_q.delete();
  endtask

  task automatic start_dl(input logic [15:0] idx);
    @(negedge clk_sys);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic end_dl();
    bus.ioctl_download = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic hps_write(input logic [24:0] addr, input logic [15:0] data, input int gap);
    int guard = 0;
    while (bus.ioctl_wait === 1'b1 && guard < 1000) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 1000) stall_timeouts++;
    bus.ioctl_addr = addr;
    bus.ioctl_dout = data;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic send_image(input int seed, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({13'(i), word_data(i, seed)});
      hps_write(25'(i * 2), word_data(i, seed), gap);
    end
  endtask

  task automatic wait_state(input state_t st, input int budget);
    int n = 0;
    while (dbg_state !== st && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
  endtask

  // Tests
  task automatic test_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if (bus.bios_wr !== 1'b0) begin bad++; $display("FAIL rst_wr got=%b exp=0", bus.bios_wr); end
    total++; if (bus.bios_addr !== 13'd0) begin bad++; $display("FAIL rst_addr got=%0h exp=0", bus.bios_addr); end
    total++; if (bus.bios_din !== 16'd0) begin bad++; $display("FAIL rst_din got=%0h exp=0", bus.bios_din); end
    total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL rst_wait got=%b exp=0", bus.ioctl_wait); end
    total++; if (bus.bios_loaded !== 1'b0) begin bad++; $display("FAIL rst_loaded got=%b exp=0", bus.bios_loaded); end
    total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL rst_err got=%b exp=00", bus.err); end
    reset_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL post_rst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_full_image();
    clear_capture();
    wait_seen = 1'b0;
    bus.bios_req = 1'b1;
    start_dl(16'd0);
    send_image(1, WORDS, 3);
    end_dl();
    wait_state(ST_DONE, 200);
    total++; if (dbg_state !== ST_DONE) begin bad++; $display("FAIL full_state got=%0d exp=%0d", dbg_state, ST_DONE); end
    total++; if (cap_n !== WORDS) begin bad++; $display("FAIL full_count got=%0d exp=%0d", cap_n, WORDS); end
    total++; if (count_bad() !== 0) begin bad++; $display("FAIL full_words bad_words=%0d exp=0", count_bad()); end
    total++; if (bus.bios_loaded !== 1'b1) begin bad++; $display("FAIL full_loaded got=%b exp=1", bus.bios_loaded); end
    total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL full_err got=%b exp=00", bus.err); end
    total++; if (wait_seen !== 1'b0) begin bad++; $display("FAIL full_nowait got=%b exp=0", wait_seen); end
  endtask

  task automatic test_back_to_back();
    clear_capture();
    wait_seen      = 1'b0;
    lvl_at_rise    = -1;
    stall_timeouts = 0;
    start_dl(16'd0);
    total++; if (bus.bios_loaded !== 1'b0) begin bad++; $display("FAIL b2b_loaded_clr got=%b exp=0", bus.bios_loaded); end
    fork
      send_image(2, WORDS, 0);
      begin
        for (int k = 0; k < 3000; k++) begin
          bus.bios_req = (k % 8 == 0);
          @(negedge clk_sys);
        end
        bus.bios_req = 1'b1;
      end
    join
    end_dl();
    wait_state(ST_DONE, 200);
    total++; if (wait_seen !== 1'b1) begin bad++; $display("FAIL b2b_wait_seen got=%b exp=1", wait_seen); end
    total++; if (lvl_at_rise !== DEPTH - 2) begin bad++; $display("FAIL b2b_wait_level got=%0d exp=%0d", lvl_at_rise, DEPTH - 2); end
    total++; if (stall_timeouts !== 0) begin bad++; $display("FAIL b2b_stall got=%0d exp=0", stall_timeouts); end
    total++; if (cap_n !== WORDS) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", cap_n, WORDS); end
    total++; if (count_bad() !== 0) begin bad++; $display("FAIL b2b_words bad_words=%0d exp=0", count_bad()); end
    total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL b2b_err got=%b exp=00", bus.err); end
    total++; if (bus.bios_loaded !== 1'b1) begin bad++; $display("FAIL b2b_loaded got=%b exp=1", bus.bios_loaded); end
  endtask

  task automatic test_short_image();
    clear_capture();
    start_dl(16'd0);
    send_image(3, 100, 1);
    end_dl();
    wait_state(ST_IDLE, 200);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL short_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if (cap_n !== 100) begin bad++; $display("FAIL short_count got=%0d exp=100", cap_n); end
    total++; if (count_bad() !== 0) begin bad++; $display("FAIL short_words bad_words=%0d exp=0", count_bad()); end
    total++; if (bus.err !== 2'b10) begin bad++; $display("FAIL short_err got=%b exp=10", bus.err); end
    total++; if (bus.bios_loaded !== 1'b0) begin bad++; $display("FAIL short_loaded got=%b exp=0", bus.bios_loaded); end
  endtask

  task automatic test_addr_error();
    clear_capture();
    start_dl(16'd0);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({13'(i), word_data(i, 4)});
      hps_write((i == 5) ? 25'h00C : 25'(i * 2), word_data(i, 4), 1);
    end
    total++; if (bus.err !== 2'b01) begin bad++; $display("FAIL addr_err_live got=%b exp=01", bus.err); end
    end_dl();
    wait_state(ST_IDLE, 200);
    total++; if (cap_n !== 10) begin bad++; $display("FAIL addr_count got=%0d exp=10", cap_n); end
    total++; if (got_addr[5] !== 13'd5) begin bad++; $display("FAIL addr_word5_addr got=%0d exp=5", got_addr[5]); end
    total++; if (got_data[5] !== word_data(5, 4)) begin bad++; $display("FAIL addr_word5_data got=%0h exp=%0h", got_data[5], word_data(5, 4)); end
    total++; if (count_bad() !== 0) begin bad++; $display("FAIL addr_words bad_words=%0d exp=0", count_bad()); end
    total++; if (bus.err !== 2'b11) begin bad++; $display("FAIL addr_err_final got=%b exp=11", bus.err); end
  endtask

  task automatic test_reset_mid_download();
    clear_capture();
    start_dl(16'd0);
    send_image(5, 3000, 0);
    @(negedge clk_sys);
    reset_n = 1'b0;
    @(negedge clk_sys);
    clear_capture();
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if (bus.bios_wr !== 1'b0) begin bad++; $display("FAIL midrst_wr got=%b exp=0", bus.bios_wr); end
    total++; if (bus.bios_addr !== 13'd0) begin bad++; $display("FAIL midrst_addr got=%0h exp=0", bus.bios_addr); end
    total++; if (bus.ioctl_wait !== 1'b0) begin bad++; $display("FAIL midrst_wait got=%b exp=0", bus.ioctl_wait); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk_sys);
    total++; if (dbg_state !== ST_IDLE) begin bad++; $display("FAIL midrst_stay_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    total++; if (cap_n !== 0) begin bad++; $display("FAIL midrst_no_wr got=%0d exp=0", cap_n); end
    end_dl();
    repeat (2) @(negedge clk_sys);
    clear_capture();
    start_dl(16'd0);
    send_image(6, WORDS, 0);
    end_dl();
    wait_state(ST_DONE, 200);
    total++; if (got_addr[0] !== 13'd0) begin bad++; $display("FAIL midrst_first_addr got=%0d exp=0", got_addr[0]); end
    total++; if (cap_n !== WORDS) begin bad++; $display("FAIL midrst_count got=%0d exp=%0d", cap_n, WORDS); end
    total++; if (count_bad() !== 0) begin bad++; $display("FAIL midrst_words bad_words=%0d exp=0", count_bad()); end
    total++; if (bus.bios_loaded !== 1'b1) begin bad++; $display("FAIL midrst_loaded got=%b exp=1", bus.bios_loaded); end
    total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL midrst_err got=%b exp=00", bus.err); end
  endtask

  task automatic test_other_index();
    clear_capture();
    start_dl(16'd1);
    for (int i = 0; i < 20; i++) hps_write(25'(i * 2), word_data(i, 7), 1);
    end_dl();
    repeat (10) @(negedge clk_sys);
    total++; if (cap_n !== 0) begin bad++; $display("FAIL other_no_wr got=%0d exp=0", cap_n); end
    total++; if (dbg_state !== ST_DONE) begin bad++; $display("FAIL other_state got=%0d exp=%0d", dbg_state, ST_DONE); end
    total++; if (bus.bios_loaded !== 1'b1) begin bad++; $display("FAIL other_loaded got=%b exp=1", bus.bios_loaded); end
    total++; if (bus.err !== 2'b00) begin bad++; $display("FAIL other_err got=%b exp=00", bus.err); end
    bus.ioctl_index = 16'd0;
  endtask

  // Sequencer and final report
  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 16'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 25'd0;
    bus.ioctl_dout     = 16'd0;
    bus.bios_req       = 1'b0;
    test_reset();
    test_full_image();
    test_back_to_back();
    test_short_image();
    test_addr_error();
    test_reset_mid_download();
    test_other_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
